// File: rtl/s2p_cond.sv
// s2p_cond: 4-lane serial-to-parallel receiver.
// Each lane delivers one bit per enabled IN_CLK_s2p edge, MSB first. Byte
// alignment is found by sliding over lane 0 until COM_SYM appears, then
// confirmed by SYNC_COMS consecutive boundary-aligned COMs before words are
// emitted with a one-cycle OUT_VALID_s2p strobe.
// Optional feature: define S2P_REALIGN_EN to let an off-boundary COM seen while
// locked restart synchronisation at the new bit offset.
module s2p_cond #(
   parameter logic [7:0]  COM_SYM   = 8'hBC,
   parameter int unsigned SYNC_COMS = 4
) (
   input  logic       IN_CLK_s2p,
   input  logic       IN_RESET_s2p,
   input  logic       IN_ENB_s2p,
   input  logic [3:0] IN_LANE_s2p,
   output logic [7:0] OUT_LANE3_s2p,
   output logic [7:0] OUT_LANE2_s2p,
   output logic [7:0] OUT_LANE1_s2p,
   output logic [7:0] OUT_LANE0_s2p,
   output logic       OUT_VALID_s2p,
   output logic       OUT_ALIGNED_s2p
);

   typedef enum logic [1:0] {
      SEARCH,
      SYNC,
      LOCKED
   } state_t;

   state_t          state, state_nxt;
   logic [3:0][7:0] sr, sr_nxt;
   logic [3:0][7:0] nxt;
   logic [3:0][7:0] out_word, out_word_nxt;
   logic [2:0]      bit_cnt, bit_cnt_nxt;
   logic [3:0]      com_cnt, com_cnt_nxt;
   logic [4:0]      com_inc;
   logic            valid_q, valid_nxt;
   logic            aligned_q, aligned_nxt;
   logic            boundary;
   logic            com_hit;

   // Shift-register view including the bit being sampled on this edge
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         nxt[k] = {sr[k][6:0], IN_LANE_s2p[k]};
      end
   end

   assign boundary = (bit_cnt == 3'd7);
   assign com_hit  = (nxt[0] == COM_SYM);
   assign com_inc  = {1'b0, com_cnt} + 5'd1;

   // State register; every field clears asynchronously on reset
   always_ff @(posedge IN_CLK_s2p or negedge IN_RESET_s2p) begin
      if (!IN_RESET_s2p) begin
         state     <= SEARCH;
         sr        <= '0;
         bit_cnt   <= '0;
         com_cnt   <= '0;
         out_word  <= '0;
         valid_q   <= 1'b0;
         aligned_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         bit_cnt   <= bit_cnt_nxt;
         com_cnt   <= com_cnt_nxt;
         out_word  <= out_word_nxt;
         valid_q   <= valid_nxt;
         aligned_q <= aligned_nxt;
      end
   end

   // Alignment search, sync confirmation and word emission
   always_comb begin
      state_nxt    = state;
      sr_nxt       = sr;
      bit_cnt_nxt  = bit_cnt;
      com_cnt_nxt  = com_cnt;
      out_word_nxt = out_word;
      valid_nxt    = 1'b0;
      aligned_nxt  = aligned_q;

      if (IN_ENB_s2p) begin
         sr_nxt      = nxt;
         bit_cnt_nxt = bit_cnt + 3'd1;

         case (state)
            SEARCH: begin
               if (com_hit) begin
                  bit_cnt_nxt = '0;
                  com_cnt_nxt = 4'd1;
                  if (SYNC_COMS == 1) begin
                     state_nxt   = LOCKED;
                     aligned_nxt = 1'b1;
                  end else begin
                     state_nxt = SYNC;
                  end
               end
            end

            SYNC: begin
               if (boundary) begin
                  if (com_hit) begin
                     com_cnt_nxt = com_inc[3:0];
                     if (com_inc == 5'(SYNC_COMS)) begin
                        state_nxt   = LOCKED;
                        aligned_nxt = 1'b1;
                     end
                  end else begin
                     com_cnt_nxt = '0;
                     state_nxt   = SEARCH;
                  end
               end
            end

            LOCKED: begin
               if (boundary) begin
                  out_word_nxt = nxt;
                  valid_nxt    = 1'b1;
               end
`ifdef S2P_REALIGN_EN
               else if (com_hit) begin
                  bit_cnt_nxt = '0;
                  com_cnt_nxt = 4'd1;
                  // a single COM already satisfies lock: just shift the boundary
                  if (SYNC_COMS != 1) begin
                     state_nxt   = SYNC;
                     aligned_nxt = 1'b0;
                  end
               end
`endif
            end

            default: begin
               state_nxt = SEARCH;
            end
         endcase
      end
   end

   assign OUT_LANE3_s2p   = out_word[3];
   assign OUT_LANE2_s2p   = out_word[2];
   assign OUT_LANE1_s2p   = out_word[1];
   assign OUT_LANE0_s2p   = out_word[0];
   assign OUT_VALID_s2p   = valid_q;
   assign OUT_ALIGNED_s2p = aligned_q;

endmodule

// File: tb/tb_s2p_cond.sv
// tb_s2p_cond: directed and randomized bench for s2p_cond.
// Words are transmitted MSB first on all four lanes; expected outputs come
// from the words the bench itself sent (a scoreboard of held output value and
// expected alignment), plus hand-derived constants for misaligned streams.
module tb_s2p_cond;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enb;
   logic [3:0] lanes;
   logic [7:0] o3, o2, o1, o0;
   logic       valid, aligned;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   logic [31:0] exp_words;
   logic        exp_aligned;

   s2p_cond #(.COM_SYM(8'hBC), .SYNC_COMS(4)) dut (
      .IN_CLK_s2p      (clk),
      .IN_RESET_s2p    (rst_n),
      .IN_ENB_s2p      (enb),
      .IN_LANE_s2p     (lanes),
      .OUT_LANE3_s2p   (o3),
      .OUT_LANE2_s2p   (o2),
      .OUT_LANE1_s2p   (o1),
      .OUT_LANE0_s2p   (o0),
      .OUT_VALID_s2p   (valid),
      .OUT_ALIGNED_s2p (aligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rw();
      return $urandom;
   endfunction

   // One clock: drive at negedge, check all outputs 1 time unit after posedge
   task automatic tick(input logic en, input logic [3:0] b, input logic exp_valid);
      @(negedge clk);
      enb   = en;
      lanes = b;
      @(posedge clk);
      #1;
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("aligned", 32'(aligned), 32'(exp_aligned));
      chk("words", {o3, o2, o1, o0}, exp_words);
   endtask

   // Send one 8-bit word per lane (w = {lane3,lane2,lane1,lane0}), MSB first
   task automatic send_word(input logic [31:0] w, input logic emit, input logic al_after,
                            input int unsigned gap_pct = 0, input int gap_after = -1,
                            input int unsigned gap_len = 0);
      for (int j = 0; j < 8; j++) begin
         logic [3:0] b;
         if (j == gap_after) begin
            for (int unsigned g = 0; g < gap_len; g++) tick(1'b0, 4'($urandom), 1'b0);
         end
         for (int g = 0; g < 3 && $urandom_range(99, 0) < gap_pct; g++) begin
            tick(1'b0, 4'($urandom), 1'b0);
         end
         for (int k = 0; k < 4; k++) b[k] = w[8*k + 7 - j];
         if (j == 7) begin
            exp_aligned = al_after;
            if (emit) exp_words = w;
         end
         tick(1'b1, b, emit && (j == 7));
      end
   endtask

   // Sends a COM on lane 0 with random data on the other lanes
   task automatic send_com(input logic al_after);
      logic [31:0] w;
      w = rw();
      w[7:0] = 8'hBC;
      send_word(w, 1'b0, al_after);
   endtask

   // Asynchronous reset asserted between edges, held for two clock edges
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_words   = '0;
      exp_aligned = 1'b0;
      chk("rst_valid", 32'(valid), 32'(1'b0));
      chk("rst_aligned", 32'(aligned), 32'(exp_aligned));
      chk("rst_words", {o3, o2, o1, o0}, exp_words);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      enb   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bc;
      logic       ev;
      int         p;
      bc          = 8'hBC;
      rst_n       = 1'b0;
      enb         = 1'b1;
      lanes       = '0;
      exp_words   = '0;
      exp_aligned = 1'b0;

      // 1: reset held with lanes toggling -> all outputs zero
      for (int i = 0; i < 4; i++) tick(1'b1, 4'($urandom), 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      enb   = 1'b0;

      // 2: three junk bits, four COMs, then A5,5A,FF,00
      tick(1'b1, {3'($urandom), 1'b1}, 1'b0);
      tick(1'b1, {3'($urandom), 1'b0}, 1'b0);
      tick(1'b1, {3'($urandom), 1'b1}, 1'b0);
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b1);
      send_word(32'hA55AFF00, 1'b1, 1'b1);

      // 3: a non-COM during sync restarts the search
      do_reset();
      send_com(1'b0);
      send_com(1'b0);
      send_word({rw() & 32'hFFFFFF00} | 32'h3C, 1'b0, 1'b0);
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b1);
      send_word(32'h77665511, 1'b1, 1'b1);

      // 4: enable gap of 5 cycles after 3 bits of C3; boundary COM passes through
      send_word(32'h9E4B21C3, 1'b1, 1'b1, 0, 3, 5);
      send_word(32'h0F0F0FBC, 1'b1, 1'b1);

      // randomized words with random enable gaps
      for (int i = 0; i < 24; i++) send_word(rw(), 1'b1, 1'b1, 25);

      // 5: reset mid-word while locked, then a fresh lock is needed
      for (int i = 0; i < 4; i++) tick(1'b1, 4'($urandom), 1'b0);
      do_reset();
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b0);
      send_word(32'h12345600, 1'b0, 1'b0);
      do_reset();
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b0);
      send_com(1'b1);
      send_word(32'h12345600, 1'b1, 1'b1);

      // 6: COM stream shifted by +3 bits on lane 0 while locked
      for (int i = 0; i < 3; i++) tick(1'b1, 4'b0000, 1'b0);
      for (int n = 1; n <= 32; n++) begin
         p = n + 3;
`ifdef S2P_REALIGN_EN
         if (n == 8) exp_aligned = 1'b0;
         if (n == 32) exp_aligned = 1'b1;
         ev = (p == 8);
`else
         ev = (p % 8 == 0);
`endif
         if (ev) exp_words = (p == 8) ? 32'h00000017 : 32'h00000097;
         tick(1'b1, {3'b000, bc[7 - ((n - 1) % 8)]}, ev);
      end
`ifdef S2P_REALIGN_EN
      send_word(32'hC0FFEE42, 1'b1, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
